taillight_sequencer: RTL and testbench

- Controller that sequences the DE10-Lite taillight LEDs (three per side, Thunderbird-style) from turn, hazard and brake switches.
- Replaces the free-running divided clock with an internal tick prescaler and an FSM in the single in_clock domain, so no derived clocks exist.
- Sits between the board switch inputs and the LEDR outputs at the top level.

---
 rtl/taillight_sequencer.sv | 103 ++++++++++
 tb/tb_taillight_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/taillight_sequencer.sv
// taillight_sequencer: Thunderbird-style taillight controller for three LEDs per side.
// Ports:
//   in_clock      system clock, rising edge
//   reset_n       asynchronous active-low reset
//   turn_left     left turn switch (asynchronous level)
//   turn_right    right turn switch (asynchronous level)
//   hazard        hazard switch (asynchronous level)
//   brake         brake switch (asynchronous level)
//   lights_left   left LEDs, bit0 innermost
//   lights_right  right LEDs, bit0 innermost
//   phase         current state code
module taillight_sequencer #(
    parameter int DIV_COUNT = 20000000
) (
    input  logic       in_clock,
    input  logic       reset_n,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] lights_left,
    output logic [2:0] lights_right,
    output logic [3:0] phase
);
    localparam int CNT_W = $clog2(DIV_COUNT);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        L1     = 4'd1,
        L2     = 4'd2,
        L3     = 4'd3,
        R1     = 4'd4,
        R2     = 4'd5,
        R3     = 4'd6,
        HZ_ON  = 4'd7,
        HZ_OFF = 4'd8
    } state_t;

    state_t           state, state_next;
    logic [3:0]       sync_a, sync_b;
    logic [CNT_W-1:0] count;
    logic             tl, tr, hz, bk, tick, req_haz, req_left, req_right;
    logic [2:0]       left_next, right_next;

    assign {bk, hz, tr, tl} = sync_b;
    assign req_haz   = hz | (tl & tr);
    assign req_left  = ~req_haz & tl;
    assign req_right = ~req_haz & tr;
    assign tick      = count == CNT_W'(DIV_COUNT - 1);

    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a       <= '0;
            sync_b       <= '0;
            count        <= '0;
            state        <= IDLE;
            lights_left  <= '0;
            lights_right <= '0;
            phase        <= '0;
        end else begin
            sync_a       <= {brake, hazard, turn_right, turn_left};
            sync_b       <= sync_a;
            // restart the prescaler on leaving IDLE so the first step is full length
            count        <= (state == IDLE && state_next != IDLE) || tick ? '0 : count + 1'b1;
            state        <= state_next;
            lights_left  <= left_next;
            lights_right <= right_next;
            phase        <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = req_haz ? HZ_ON : req_left ? L1 : req_right ? R1 : IDLE;
            L1:     if (tick) state_next = req_haz ? HZ_ON : req_left ? L2 : IDLE;
            L2:     if (tick) state_next = req_haz ? HZ_ON : req_left ? L3 : IDLE;
            R1:     if (tick) state_next = req_haz ? HZ_ON : req_right ? R2 : IDLE;
            R2:     if (tick) state_next = req_haz ? HZ_ON : req_right ? R3 : IDLE;
            L3, R3: if (tick) state_next = req_haz ? HZ_ON : IDLE;
            HZ_ON:  if (tick) state_next = HZ_OFF;
            HZ_OFF: if (tick) state_next = req_haz ? HZ_ON : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs are registered from the next state so they change with the state register
    always_comb begin
        left_next  = bk ? 3'b111 : 3'b000;
        right_next = bk ? 3'b111 : 3'b000;
        case (state_next)
            L1:     left_next  = 3'b001;
            L2:     left_next  = 3'b011;
            L3:     left_next  = 3'b111;
            R1:     right_next = 3'b001;
            R2:     right_next = 3'b011;
            R3:     right_next = 3'b111;
            HZ_ON:  {left_next, right_next} = 6'b111111;
            HZ_OFF: {left_next, right_next} = 6'b000000;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_taillight_sequencer.sv
// tb_taillight_sequencer: directed bench for taillight_sequencer with DIV_COUNT=4.
module tb_taillight_sequencer;
    logic       in_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       turn_left = 1'b0, turn_right = 1'b0, hazard = 1'b0, brake = 1'b0;
    logic [2:0] lights_left, lights_right;
    logic [3:0] phase;
    int         checks = 0;
    int         errors = 0;

    taillight_sequencer #(.DIV_COUNT(4)) dut (
        .in_clock(in_clock),
        .reset_n(reset_n),
        .turn_left(turn_left),
        .turn_right(turn_right),
        .hazard(hazard),
        .brake(brake),
        .lights_left(lights_left),
        .lights_right(lights_right),
        .phase(phase)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] l, input logic [2:0] r, input logic [3:0] p);
        check({tag, ".left"}, {5'd0, lights_left}, {5'd0, l});
        check({tag, ".right"}, {5'd0, lights_right}, {5'd0, r});
        check({tag, ".phase"}, {4'd0, phase}, {4'd0, p});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge in_clock);
        #1;
    endtask

    initial begin
        // reset with turn_left held
        turn_left = 1'b1;
        cyc(3);
        expect_out("rst", 3'b000, 3'b000, 4'd0);
        reset_n = 1'b1;
        cyc(2);
        expect_out("lat2", 3'b000, 3'b000, 4'd0);
        cyc(1);
        expect_out("l1", 3'b001, 3'b000, 4'd1);
        cyc(3);
        expect_out("l1hold", 3'b001, 3'b000, 4'd1);
        cyc(1);
        expect_out("l2", 3'b011, 3'b000, 4'd2);
        cyc(4);
        expect_out("l3", 3'b111, 3'b000, 4'd3);
        cyc(4);
        expect_out("loff", 3'b000, 3'b000, 4'd0);
        cyc(1);
        expect_out("lrep", 3'b001, 3'b000, 4'd1);
        turn_left = 1'b0;
        cyc(10);
        expect_out("lidle", 3'b000, 3'b000, 4'd0);

        // turn_right dropped during R2
        turn_right = 1'b1;
        cyc(3);
        expect_out("r1", 3'b000, 3'b001, 4'd4);
        cyc(4);
        expect_out("r2", 3'b000, 3'b011, 4'd5);
        turn_right = 1'b0;
        cyc(3);
        expect_out("r2hold", 3'b000, 3'b011, 4'd5);
        cyc(1);
        expect_out("rabort", 3'b000, 3'b000, 4'd0);

        // hazard, brake ignored
        hazard = 1'b1;
        cyc(3);
        expect_out("hzon", 3'b111, 3'b111, 4'd7);
        cyc(4);
        expect_out("hzoff", 3'b000, 3'b000, 4'd8);
        cyc(4);
        expect_out("hzon2", 3'b111, 3'b111, 4'd7);
        brake = 1'b1;
        cyc(4);
        expect_out("hzoffbk", 3'b000, 3'b000, 4'd8);
        cyc(4);
        expect_out("hzonbk", 3'b111, 3'b111, 4'd7);
        hazard = 1'b0;
        brake = 1'b0;
        cyc(10);
        expect_out("hzidle", 3'b000, 3'b000, 4'd0);

        // left turn with brake
        brake = 1'b1;
        cyc(3);
        expect_out("bkidle", 3'b111, 3'b111, 4'd0);
        turn_left = 1'b1;
        cyc(3);
        expect_out("bkl1", 3'b001, 3'b111, 4'd1);
        cyc(4);
        expect_out("bkl2", 3'b011, 3'b111, 4'd2);
        cyc(4);
        expect_out("bkl3", 3'b111, 3'b111, 4'd3);
        cyc(4);
        expect_out("bkoff", 3'b111, 3'b111, 4'd0);
        cyc(1);
        expect_out("bkrep", 3'b001, 3'b111, 4'd1);
        turn_left = 1'b0;
        brake = 1'b0;
        cyc(10);
        expect_out("bkend", 3'b000, 3'b000, 4'd0);

        // both turns act as hazard
        turn_left = 1'b1;
        turn_right = 1'b1;
        cyc(3);
        expect_out("bothon", 3'b111, 3'b111, 4'd7);
        cyc(4);
        expect_out("bothoff", 3'b000, 3'b000, 4'd8);
        cyc(4);
        expect_out("bothon2", 3'b111, 3'b111, 4'd7);
        turn_left = 1'b0;
        turn_right = 1'b0;
        cyc(10);
        expect_out("bothidle", 3'b000, 3'b000, 4'd0);

        // hazard during L2
        turn_left = 1'b1;
        cyc(3);
        expect_out("hl1", 3'b001, 3'b000, 4'd1);
        cyc(4);
        expect_out("hl2", 3'b011, 3'b000, 4'd2);
        hazard = 1'b1;
        cyc(3);
        expect_out("hl2hold", 3'b011, 3'b000, 4'd2);
        cyc(1);
        expect_out("hlhz", 3'b111, 3'b111, 4'd7);
        hazard = 1'b0;
        turn_left = 1'b0;
        cyc(10);
        expect_out("hlidle", 3'b000, 3'b000, 4'd0);

        // asynchronous reset during L3
        turn_left = 1'b1;
        cyc(11);
        expect_out("pl3", 3'b111, 3'b000, 4'd3);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("arst", 3'b000, 3'b000, 4'd0);
        #1;
        reset_n = 1'b1;
        cyc(3);
        expect_out("postrst", 3'b001, 3'b000, 4'd1);
        turn_left = 1'b0;
        cyc(10);
        expect_out("end", 3'b000, 3'b000, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
